// File: rtl/riscv_core_mul_out_q.sv
// Multiplier output stage: picks and sign-extends the XLEN-bit result from the full
// product, then queues result and tag in a small FIFO with valid/ready handshakes on both sides.
module riscv_core_mul_out_q #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAGW  = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_mul_out_flush,
  input  logic                     i_mul_out_valid,
  output logic                     o_mul_out_ready,
  input  logic [1:0]               i_mul_out_control,
  input  logic                     i_mul_out_isword,
  input  logic [2*XLEN-1:0]        i_mul_out_product,
  input  logic [TAGW-1:0]          i_mul_out_tag,
  output logic                     o_mul_out_valid,
  input  logic                     i_mul_out_ready,
  output logic [XLEN-1:0]          o_mul_out_result,
  output logic [TAGW-1:0]          o_mul_out_tag,
  output logic [$clog2(DEPTH):0]   o_mul_out_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int HALF = XLEN / 2;
  localparam bit HAS_WORD_OPS = (XLEN == 64);

  logic [XLEN-1:0] res_mem [DEPTH];
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] sel_result;

  // Ready is decoded from the registered count only, so a full queue never pops through.
  assign o_mul_out_ready = (count < CNTW'(DEPTH));
  assign o_mul_out_valid = (count != '0);
  assign push            = i_mul_out_valid & o_mul_out_ready;
  assign pop             = o_mul_out_valid & i_mul_out_ready;

  always_comb begin
    sel_result = i_mul_out_product[XLEN-1:0];
    if (HAS_WORD_OPS && i_mul_out_isword) begin
      sel_result = {{HALF{i_mul_out_product[HALF-1]}}, i_mul_out_product[HALF-1:0]};
    end else if (i_mul_out_control != 2'b00) begin
      sel_result = i_mul_out_product[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_mul_out_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      if (push && !pop) begin
        count <= count + CNTW'(1);
      end else if (!push && pop) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only visible once the count covers it.
  always_ff @(posedge i_clk) begin
    if (push && !i_mul_out_flush) begin
      res_mem[wr_ptr] <= sel_result;
      tag_mem[wr_ptr] <= i_mul_out_tag;
    end
  end

  assign o_mul_out_result = o_mul_out_valid ? res_mem[rd_ptr] : '0;
  assign o_mul_out_tag    = o_mul_out_valid ? tag_mem[rd_ptr] : '0;
  assign o_mul_out_count  = count;

endmodule

// File: tb/tb_riscv_core_mul_out_q.sv
// Bench for riscv_core_mul_out_q: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based reference model.
module tb_riscv_core_mul_out_q;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int TAGW  = 5;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [TAGW-1:0] tag;
  } entry_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              inValid;
  logic              outReady;
  logic [1:0]        control;
  logic              isWord;
  logic [2*XLEN-1:0] product;
  logic [TAGW-1:0]   inTag;
  logic              outValid;
  logic              inReady;
  logic [XLEN-1:0]   outResult;
  logic [TAGW-1:0]   outTag;
  logic [1:0]        outCount;

  int     assertCount = 0;
  int     failCount   = 0;
  entry_t modelQ[$];
  bit     modelPush;
  bit     modelPop;

  localparam logic [2*XLEN-1:0] P1 = {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_8000_0001};

  riscv_core_mul_out_q #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_mul_out_flush   (flush),
    .i_mul_out_valid   (inValid),
    .o_mul_out_ready   (outReady),
    .i_mul_out_control (control),
    .i_mul_out_isword  (isWord),
    .i_mul_out_product (product),
    .i_mul_out_tag     (inTag),
    .o_mul_out_valid   (outValid),
    .i_mul_out_ready   (inReady),
    .o_mul_out_result  (outResult),
    .o_mul_out_tag     (outTag),
    .o_mul_out_count   (outCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result selection expressed arithmetically: word ops are the signed low 32 bits,
  // MUL keeps the product modulo 2^64, the high variants take product / 2^64.
  function automatic logic [XLEN-1:0] refSelect(input logic [2*XLEN-1:0] p,
                                                 input logic [1:0] ctrl,
                                                 input logic word);
    int          lo;
    logic [2*XLEN-1:0] hi;
    if (word) begin
      lo = p[31:0];
      return 64'(longint'(lo));
    end
    if (ctrl == 2'b00) return p[XLEN-1:0];
    hi = p >> XLEN;
    return hi[XLEN-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, let one rising edge pass, return just after it.
  task automatic applyStimulus(input logic v, input logic [1:0] ctrl, input logic word,
                               input logic [2*XLEN-1:0] p, input logic [TAGW-1:0] tag,
                               input logic rdy, input logic fl);
    inValid = v;
    control = ctrl;
    isWord  = word;
    product = p;
    inTag   = tag;
    inReady = rdy;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a bounded queue, cleared by reset or flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
    end else if (flush) begin
      modelQ.delete();
    end else begin
      modelPush = inValid && (modelQ.size() < DEPTH);
      modelPop  = (modelQ.size() > 0) && inReady;
      if (modelPop) void'(modelQ.pop_front());
      if (modelPush) modelQ.push_back('{res: refSelect(product, control, isWord), tag: inTag});
    end
  end

  always @(negedge clk) begin
    checkOutput("valid", 64'(outValid), 64'(modelQ.size() != 0));
    checkOutput("ready", 64'(outReady), 64'(modelQ.size() < DEPTH));
    checkOutput("count", 64'(outCount), 64'(modelQ.size()));
    checkOutput("result", outResult, (modelQ.size() != 0) ? modelQ[0].res : 64'd0);
    checkOutput("tag", 64'(outTag), (modelQ.size() != 0) ? 64'(modelQ[0].tag) : 64'd0);
  end

  initial begin
    rst_n = 1'b0;
    inValid = 0; control = 0; isWord = 0; product = '0; inTag = 0; inReady = 0; flush = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_count", 64'(outCount), 64'd0);
    checkOutput("rst_ready", 64'(outReady), 64'd1);

    // Single MUL push, popped on the following edge
    applyStimulus(1, 2'b00, 0, P1, 5'd3, 1, 0);
    checkOutput("t1_valid", 64'(outValid), 64'd1);
    checkOutput("t1_result", outResult, 64'h0000_0000_8000_0001);
    checkOutput("t1_tag", 64'(outTag), 64'd3);
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);
    checkOutput("t1_count_after_pop", 64'(outCount), 64'd0);
    checkOutput("t1_result_zero", outResult, 64'd0);

    // High-half variants and the word op
    for (int c = 1; c < 4; c++) begin
      applyStimulus(1, 2'(c), 0, P1, 5'd4, 1, 0);
      checkOutput("t2_high_result", outResult, 64'hFFFF_FFFF_FFFF_FFFE);
      applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);
    end
    applyStimulus(1, 2'b10, 1, P1, 5'd4, 1, 0);
    checkOutput("t2_word_result", outResult, 64'hFFFF_FFFF_8000_0001);
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);

    // Back-pressure ordering, then push and pop on the same edge at count 1
    applyStimulus(1, 2'b00, 0, 128'd11, 5'd1, 0, 0);
    applyStimulus(1, 2'b00, 0, 128'd22, 5'd2, 0, 0);
    checkOutput("t3_count_full", 64'(outCount), 64'd2);
    checkOutput("t3_ready_full", 64'(outReady), 64'd0);
    checkOutput("t3_head_tag1", 64'(outTag), 64'd1);
    applyStimulus(1, 2'b00, 0, 128'd33, 5'd3, 1, 0);
    checkOutput("t3_head_tag2", 64'(outTag), 64'd2);
    checkOutput("t3_count_one", 64'(outCount), 64'd1);
    applyStimulus(1, 2'b00, 0, 128'd33, 5'd3, 1, 0);
    checkOutput("t4_count_same", 64'(outCount), 64'd1);
    checkOutput("t4_head_tag3", 64'(outTag), 64'd3);
    checkOutput("t4_head_result", outResult, 64'd33);
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);
    checkOutput("t4_drained", 64'(outCount), 64'd0);

    // Flush on a full queue with a push on the same edge
    applyStimulus(1, 2'b00, 0, 128'd44, 5'd4, 0, 0);
    applyStimulus(1, 2'b00, 0, 128'd55, 5'd5, 0, 0);
    inValid = 1; inTag = 5'd9; product = 128'd99; flush = 1;
    #1;
    checkOutput("t5_preflush_count", 64'(outCount), 64'd2);
    @(posedge clk);
    #1;
    checkOutput("t5_count", 64'(outCount), 64'd0);
    checkOutput("t5_valid", 64'(outValid), 64'd0);
    checkOutput("t5_result", outResult, 64'd0);
    checkOutput("t5_ready", 64'(outReady), 64'd1);
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);
    checkOutput("t5_no_ghost", 64'(outValid), 64'd0);

    // Asynchronous reset with a full queue
    applyStimulus(1, 2'b00, 0, 128'd66, 5'd6, 0, 0);
    applyStimulus(1, 2'b00, 0, 128'd77, 5'd7, 0, 0);
    inValid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(outValid), 64'd0);
    checkOutput("t6_rst_result", outResult, 64'd0);
    checkOutput("t6_rst_count", 64'(outCount), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 2'b01, 0, P1, 5'd12, 0, 0);
    checkOutput("t6_post_count", 64'(outCount), 64'd1);
    checkOutput("t6_post_result", outResult, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("t6_post_tag", 64'(outTag), 64'd12);
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 5'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);
    applyStimulus(0, 2'b00, 0, '0, 5'd0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
